// File: rtl/frog_pkg.sv
// Shared definitions for the frog game board I/O path.
// Holds the state encoding used by event_stretch and the output-level
// helper that turns an ACTIVE_LOW setting into a concrete pin level.
// The debounce modules may reuse the level constants from here.
package frog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic LEVEL_LOW  = 1'b0;
    localparam logic LEVEL_HIGH = 1'b1;

    // Level a pin shows when its signal is asserted, given its polarity.
    function automatic logic active_level(input logic active_low);
        return active_low ? LEVEL_LOW : LEVEL_HIGH;
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag.
// A load takes priority over a decrement, and the count only decrements
// while nonzero, so it saturates at zero instead of wrapping.
module load_down_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise decrement only while nonzero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/event_stretch.sv
// event_stretch: turns single-cycle game event pulses into held,
// minimum-width output levels for an LED or buzzer pin, with a mandatory
// idle gap between holds and a one-deep queue for events arriving while
// the output is busy.
// Optional feature macro: EVENT_STRETCH_RETRIGGER_EN -- when defined, an
// event during HOLD restarts the hold count instead of being queued.
// rst is active low and asynchronous.
module event_stretch
    import frog_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 6,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic busy,
    output logic dropped
);

    // Counter reload values; the counter runs N-1 down to 0 for N cycles.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic ACT_LEVEL = active_level(ACTIVE_LOW != 0);

    state_e           state_q;
    state_e           state_d;
    logic             pending_q;
    logic             pending_d;
    logic             dropped_q;
    logic             dropped_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             retrig_hit;

`ifdef EVENT_STRETCH_RETRIGGER_EN
    assign retrig_hit = in;
`else
    assign retrig_hit = 1'b0;
`endif

    load_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec_en   (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next state, queue bookkeeping and counter control.
    // An event on the edge a HOLD or GAP ends still belongs to that state:
    // it is queued if the queue is empty, or dropped if the queue is full
    // even though the queued entry is consumed on that same edge.
    // A queued event left behind when entering IDLE is served from IDLE.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        dropped_d    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = HOLD_LOAD;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q || in) begin
                    state_d   = HOLD;
                    cnt_load  = 1'b1;
                    pending_d = pending_q & in;
                end
            end
            HOLD: begin
                if (retrig_hit) begin
                    cnt_load = 1'b1;
                end else begin
                    if (in) begin
                        if (pending_q) begin
                            dropped_d = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                    if (cnt_zero) begin
                        if (GAP_CYCLES > 0) begin
                            state_d      = GAP;
                            cnt_load     = 1'b1;
                            cnt_load_val = GAP_LOAD;
                        end else if (pending_q) begin
                            cnt_load  = 1'b1;
                            pending_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            GAP: begin
                if (in) begin
                    if (pending_q) begin
                        dropped_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (cnt_zero) begin
                    if (pending_q) begin
                        state_d   = HOLD;
                        cnt_load  = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // State, queue and drop-pulse registers; reset discards any queued event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    assign out     = (state_q == HOLD) ? ACT_LEVEL : ~ACT_LEVEL;
    assign busy    = (state_q != IDLE);
    assign dropped = dropped_q;

endmodule

// File: tb/tb_event_stretch.sv
// Scoreboard bench for event_stretch: the stimulus process pushes the
// hand-computed expected pin values for each cycle into a queue, and a
// monitor pops and compares them just after every rising edge.
// Instance dut_a uses the defaults; dut_g uses GAP_CYCLES=0.
module tb_event_stretch;

    logic clk;
    logic rst;
    logic in_a;
    logic in_g;
    logic out_a;
    logic busy_a;
    logic dropped_a;
    logic out_g;
    logic busy_g;
    logic dropped_g;

    int total_count;
    int bad_count;

    typedef struct {
        int    sel;
        int    cyc;
        logic  out;
        logic  busy;
        logic  drop;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_item;

    event_stretch dut_a (
        .clk     (clk),
        .rst     (rst),
        .in      (in_a),
        .out     (out_a),
        .busy    (busy_a),
        .dropped (dropped_a)
    );

    event_stretch #(
        .HOLD_CYCLES (10),
        .GAP_CYCLES  (0),
        .CNT_W       (6),
        .ACTIVE_LOW  (1)
    ) dut_g (
        .clk     (clk),
        .rst     (rst),
        .in      (in_g),
        .out     (out_g),
        .busy    (busy_g),
        .dropped (dropped_g)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bitAt(input int c);
        logic [63:0] m;
        m = '0;
        m[c] = 1'b1;
        return m;
    endfunction

    task automatic checkOutput(input string name, input int cyc, input logic actual, input logic expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, actual, expected);
        end
    endtask

    // Drives one scenario. Bit c of ev means in=1 sampled on edge c; bit k of the
    // masks gives the expected hold/busy/drop state during cycle k (after edge k-1).
    task automatic applyStimulus(input string name, input int sel, input logic [63:0] ev,
                                 input logic [63:0] hold_m, input logic [63:0] busy_m,
                                 input logic [63:0] drop_m, input int ncyc);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (sel == 0) in_a = ev[c]; else in_g = ev[c];
            e.sel  = sel;
            e.cyc  = c + 1;
            e.out  = ~hold_m[c+1];
            e.busy = busy_m[c+1];
            e.drop = drop_m[c+1];
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        in_a = 1'b0;
        in_g = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: compare the DUT pins against the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_item = sb.pop_front();
            if (mon_item.sel == 0) begin
                checkOutput({mon_item.name, ".out"},     mon_item.cyc, out_a,     mon_item.out);
                checkOutput({mon_item.name, ".busy"},    mon_item.cyc, busy_a,    mon_item.busy);
                checkOutput({mon_item.name, ".dropped"}, mon_item.cyc, dropped_a, mon_item.drop);
            end else begin
                checkOutput({mon_item.name, ".out"},     mon_item.cyc, out_g,     mon_item.out);
                checkOutput({mon_item.name, ".busy"},    mon_item.cyc, busy_g,    mon_item.busy);
                checkOutput({mon_item.name, ".dropped"}, mon_item.cyc, dropped_g, mon_item.drop);
            end
        end
    end

    // Bound on total run time.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total_count = 0;
        bad_count   = 0;
        rst  = 1'b0;
        in_a = 1'b0;
        in_g = 1'b0;
        #1;
        checkOutput("reset.out_a",     0, out_a,     1'b1);
        checkOutput("reset.busy_a",    0, busy_a,    1'b0);
        checkOutput("reset.dropped_a", 0, dropped_a, 1'b0);
        checkOutput("reset.out_g",     0, out_g,     1'b1);
        checkOutput("reset.busy_g",    0, busy_g,    1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus("single", 0, bitAt(0), rng(1, 10), rng(1, 14), '0, 20);
        applyStimulus("gap_term_queue", 0, bitAt(0) | bitAt(14),
                      rng(1, 10) | rng(16, 25), rng(1, 14) | rng(16, 29), '0, 34);
`ifndef EVENT_STRETCH_RETRIGGER_EN
        applyStimulus("queued", 0, bitAt(0) | bitAt(5),
                      rng(1, 10) | rng(15, 24), rng(1, 28), '0, 32);
        applyStimulus("dropped", 0, bitAt(0) | bitAt(5) | bitAt(7),
                      rng(1, 10) | rng(15, 24), rng(1, 28), bitAt(8), 32);
        applyStimulus("gap_term_drop", 0, bitAt(0) | bitAt(5) | bitAt(14),
                      rng(1, 10) | rng(15, 24), rng(1, 28), bitAt(15), 32);
        applyStimulus("nogap", 1, bitAt(0) | bitAt(3), rng(1, 20), rng(1, 20), '0, 24);
`else
        applyStimulus("retrig", 0, bitAt(0) | bitAt(6), rng(1, 16), rng(1, 20), '0, 26);
        applyStimulus("retrig_nogap", 1, bitAt(0) | bitAt(3), rng(1, 13), rng(1, 13), '0, 18);
`endif

        // Events on edges 0 and 2, then asynchronous reset in the middle of cycle 4.
        @(negedge clk); in_a = 1'b1;
        @(negedge clk); in_a = 1'b0;
        @(negedge clk); in_a = 1'b1;
        @(negedge clk); in_a = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("pre_reset.out",  4, out_a,  1'b0);
        checkOutput("pre_reset.busy", 4, busy_a, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("async_reset.out",     4, out_a,     1'b1);
        checkOutput("async_reset.busy",    4, busy_a,    1'b0);
        checkOutput("async_reset.dropped", 4, dropped_a, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("after_reset_idle", 0, '0, '0, '0, '0, 20);
        applyStimulus("after_reset_event", 0, bitAt(0), rng(1, 10), rng(1, 14), '0, 20);

        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
